// File: rtl/led_pattern_monitor_pkg.sv
// Shared types and constants for the LED bounce monitor.
// Phase pattern table, FSM state type and speed width.
package led_pattern_monitor_pkg;

  localparam int SPEED_W = 2;
  localparam int PHASE_W = 3;
  localparam int NPHASE  = 6;

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  // Entry [p] is the LED pattern of bounce phase p.
  localparam logic [NPHASE-1:0][3:0] PHASE_PAT = {
    4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001
  };

  function automatic logic [PHASE_W-1:0] next_phase(
    input logic [PHASE_W-1:0] p
  );
    return (p == PHASE_W'(NPHASE - 1)) ?
      '0 : p + PHASE_W'(1);
  endfunction

endpackage

// File: rtl/led_pattern_monitor_dwell_timer.sv
// Dwell counter for one LED pattern.
// Flags an exact speed match and a saturated stall.
module dwell_timer
  import led_pattern_monitor_pkg::*;
#(
  parameter int DIV_W = 25
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               restart,
  output logic               match,
  output logic [SPEED_W-1:0] speed,
  output logic               stall
);

  localparam int CW = DIV_W + 1;
  localparam int unsigned SATI = (32'd1 << DIV_W) + 32'd1;
  localparam logic [CW-1:0] SAT = SATI[CW-1:0];

  logic [CW-1:0] cnt;

  // Count cycles since the last pattern change, saturating.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(1);
    end else if (cnt != SAT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Exact match against each speed's dwell length.
  always_comb begin
    match = 1'b0;
    speed = '0;
    for (int s = 0; s < 4; s++) begin
      if (cnt == CW'(32'd1 << (DIV_W - s))) begin
        match = 1'b1;
        speed = SPEED_W'(s);
      end
    end
  end

  assign stall = (cnt == SAT);

endmodule

// File: rtl/led_pattern_monitor.sv
// Bus monitor for the 4-LED bounce display.
// Tracks phase, decodes speed, counts errors.
module led_pattern_monitor
  import led_pattern_monitor_pkg::*;
#(
  parameter int DIV_W = 25
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         LED,
  output logic [SPEED_W-1:0] SPEED,
  output logic               SPEED_VALID,
  output logic               LOCKED,
  output logic               STEP,
  output logic               ERR,
  output logic [7:0]         ERR_CNT
);

  logic [3:0]         led_q;
  logic [3:0]         led_qq;
  state_t             state;
  state_t             state_n;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_n;
  logic [PHASE_W-1:0] nxt;
  logic               meas;
  logic               meas_n;
  logic [SPEED_W-1:0] spd_n;
  logic               vld_n;
  logic               step_n;
  logic               err_n;
  logic               chg;
  logic               match;
  logic               stall;
  logic [SPEED_W-1:0] tspd;

  assign chg = (led_q != led_qq);
  assign nxt = next_phase(phase);

  // Register the bus and keep the previous sample.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led_q  <= '0;
      led_qq <= '0;
    end else begin
      led_q  <= LED;
      led_qq <= led_q;
    end
  end

  dwell_timer #(
    .DIV_W(DIV_W)
  ) u_dwell (
    .CLK    (CLK),
    .RST    (RST),
    .restart(chg),
    .match  (match),
    .speed  (tspd),
    .stall  (stall)
  );

  // Phase FSM and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= HUNT;
      phase       <= '0;
      meas        <= 1'b0;
      SPEED       <= '0;
      SPEED_VALID <= 1'b0;
      LOCKED      <= 1'b0;
      STEP        <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      meas        <= meas_n;
      SPEED       <= spd_n;
      SPEED_VALID <= vld_n;
      LOCKED      <= (state_n == LOCK);
      STEP        <= step_n;
      ERR         <= err_n;
    end
  end

  // Next state: relock in HUNT, follow or break in LOCK.
  always_comb begin
    state_n = state;
    phase_n = phase;
    meas_n  = meas;
    spd_n   = SPEED;
    vld_n   = SPEED_VALID;
    step_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      HUNT: begin
        vld_n  = 1'b0;
        meas_n = 1'b0;
        unique case (1'b1)
          (led_q == PHASE_PAT[0]): begin
            state_n = LOCK;
            phase_n = PHASE_W'(0);
          end
          (led_q == PHASE_PAT[3]): begin
            state_n = LOCK;
            phase_n = PHASE_W'(3);
          end
          default: ;
        endcase
      end
      LOCK: begin
        if (chg) begin
          if (led_q == PHASE_PAT[nxt]) begin
            phase_n = nxt;
            step_n  = 1'b1;
            meas_n  = 1'b1;
            if (meas) begin
              vld_n = match;
              if (match) spd_n = tspd;
            end
          end else begin
            err_n   = 1'b1;
            vld_n   = 1'b0;
            meas_n  = 1'b0;
            state_n = HUNT;
          end
        end else if (stall) begin
          vld_n = 1'b0;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Saturating error counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ERR_CNT <= '0;
    end else if (err_n && ERR_CNT != 8'hFF) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor with DIV_W=6.
// Event-level model plus directed literal checks.
module tb_led_pattern_monitor;

  localparam int DW  = 6;
  localparam int SAT = (1 << DW) + 1;
  localparam logic [3:0] PAT [6] = '{
    4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0100, 4'b0010
  };

  logic       CLK;
  logic       RST;
  logic [3:0] LED;
  logic [1:0] SPEED;
  logic       SPEED_VALID;
  logic       LOCKED;
  logic       STEP;
  logic       ERR;
  logic [7:0] ERR_CNT;

  led_pattern_monitor #(
    .DIV_W(DW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LED        (LED),
    .SPEED      (SPEED),
    .SPEED_VALID(SPEED_VALID),
    .LOCKED     (LOCKED),
    .STEP       (STEP),
    .ERR        (ERR),
    .ERR_CNT    (ERR_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int ncmp  = 0;
  int nfail = 0;
  int nstep = 0;
  int nerrp = 0;
  int dp    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: edge index n, last change edge, phase as integer.
  int         n;
  int         lastchg;
  int         mphase;
  int         mspd;
  int         merrc;
  bit         mhunt;
  bit         mmeas;
  bit         mvld;
  bit         mstep;
  bit         merr;
  logic [3:0] cur;
  logic [3:0] prev;

  task automatic mreset();
    n = 0; lastchg = 1; mphase = 0; mspd = 0; merrc = 0;
    mhunt = 1; mmeas = 0; mvld = 0; mstep = 0; merr = 0;
    cur = '0; prev = '0;
  endtask

  task automatic madvance();
    int dw;
    int nx;
    int found;
    bit chg;
    n++;
    dw = n - lastchg;
    if (dw > SAT) dw = SAT;
    chg = (cur != prev);
    mstep = 0;
    merr = 0;
    if (mhunt) begin
      mmeas = 0;
      mvld = 0;
      if (cur == 4'b0001) begin
        mhunt = 0; mphase = 0;
      end else if (cur == 4'b1000) begin
        mhunt = 0; mphase = 3;
      end
    end else if (chg) begin
      nx = (mphase + 1) % 6;
      if (cur == PAT[nx]) begin
        mphase = nx;
        mstep = 1;
        if (mmeas) begin
          found = -1;
          for (int s = 0; s < 4; s++)
            if (dw == (1 << (DW - s))) found = s;
          if (found >= 0) begin
            mspd = found;
            mvld = 1;
          end else begin
            mvld = 0;
          end
        end
        mmeas = 1;
      end else begin
        merr = 1;
        if (merrc < 255) merrc++;
        mvld = 0;
        mmeas = 0;
        mhunt = 1;
      end
    end else if (dw == SAT) begin
      mvld = 0;
    end
    if (chg) lastchg = n;
    prev = cur;
    cur = LED;
  endtask

  initial mreset();

  always @(posedge CLK or negedge RST) begin
    if (!RST) mreset();
    else madvance();
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("speed", int'(SPEED), mspd);
    chk("speed_valid", int'(SPEED_VALID), int'(mvld));
    chk("locked", int'(LOCKED), int'(!mhunt));
    chk("step", int'(STEP), int'(mstep));
    chk("err", int'(ERR), int'(merr));
    chk("err_cnt", int'(ERR_CNT), merrc);
    if (RST) begin
      if (STEP) nstep++;
      if (ERR) nerrp++;
    end
  end

  task automatic nxt(input int d);
    dp = (dp + 1) % 6;
    LED = PAT[dp];
    repeat (d) @(negedge CLK);
  endtask

  int s0;
  int e0;

  initial begin
    RST = 1'b0;
    LED = 4'b0000;
    repeat (2) @(negedge CLK);
    chk("rst_speed", int'(SPEED), 0);
    chk("rst_valid", int'(SPEED_VALID), 0);
    chk("rst_locked", int'(LOCKED), 0);
    chk("rst_step", int'(STEP), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_errcnt", int'(ERR_CNT), 0);

    LED = 4'b0001;
    dp = 0;
    RST = 1'b1;
    @(negedge CLK);
    chk("lock_1edge", int'(LOCKED), 0);
    @(negedge CLK);
    chk("lock_2edge", int'(LOCKED), 1);
    repeat (62) @(negedge CLK);

    s0 = nstep;
    repeat (6) nxt(64);
    chk("bounce_steps", nstep - s0, 6);
    chk("s0_speed", int'(SPEED), 0);
    chk("s0_valid", int'(SPEED_VALID), 1);

    repeat (12) nxt(8);
    chk("s3_speed", int'(SPEED), 3);
    chk("s3_valid", int'(SPEED_VALID), 1);
    chk("s3_errcnt", int'(ERR_CNT), 0);

    nxt(16);
    nxt(16);
    chk("s2_speed", int'(SPEED), 2);
    chk("s2_valid", int'(SPEED_VALID), 1);
    nxt(37);
    nxt(32);
    chk("odd_valid", int'(SPEED_VALID), 0);
    chk("odd_speed_held", int'(SPEED), 2);
    nxt(32);
    chk("s1_speed", int'(SPEED), 1);
    chk("s1_valid", int'(SPEED_VALID), 1);

    for (int i = 0; i < 6 && dp != 2; i++) nxt(8);
    e0 = nerrp;
    LED = 4'b0001;
    @(negedge CLK);
    LED = 4'b1000;
    dp = 3;
    @(negedge CLK);
    chk("brk_locked", int'(LOCKED), 0);
    chk("brk_err", int'(ERR), 1);
    chk("brk_errcnt", int'(ERR_CNT), 1);
    @(negedge CLK);
    chk("relock_p3", int'(LOCKED), 1);
    repeat (16) @(negedge CLK);
    repeat (6) nxt(8);
    chk("one_err_only", nerrp - e0, 1);
    chk("errcnt_one", int'(ERR_CNT), 1);

    repeat (256) begin
      LED = 4'b0110;
      repeat (2) @(negedge CLK);
      LED = 4'b0001;
      repeat (2) @(negedge CLK);
    end
    dp = 0;
    chk("err_pulses", nerrp - e0, 257);
    chk("errcnt_sat", int'(ERR_CNT), 255);

    repeat (6) nxt(8);
    chk("pre_stall_valid", int'(SPEED_VALID), 1);
    LED = 4'b0010;
    dp = 1;
    repeat (40) @(negedge CLK);
    chk("mid_dwell_valid", int'(SPEED_VALID), 1);
    repeat (30) @(negedge CLK);
    chk("stall_valid", int'(SPEED_VALID), 0);
    chk("stall_locked", int'(LOCKED), 1);

    #2 RST = 1'b0;
    #1;
    chk("arst_speed", int'(SPEED), 0);
    chk("arst_valid", int'(SPEED_VALID), 0);
    chk("arst_locked", int'(LOCKED), 0);
    chk("arst_step", int'(STEP), 0);
    chk("arst_err", int'(ERR), 0);
    chk("arst_errcnt", int'(ERR_CNT), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("hunt_ignore", int'(LOCKED), 0);
    LED = 4'b0001;
    repeat (3) @(negedge CLK);
    chk("relock_rst", int'(LOCKED), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
